// File: rtl/xor_gate_selftest_ctrl_if.sv
// xor_gate_selftest_ctrl_if: host-side start/abort handshake and result bus of the XOR self-test sequencer.
interface xor_gate_selftest_ctrl_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       fail_vec;
    logic             fail_seen;
    modport master (output start, abort, input busy, done, pass, err_count, fail_vec, fail_seen);
    modport slave  (input start, abort, output busy, done, pass, err_count, fail_vec, fail_seen);
endinterface

// File: rtl/xor_gate_selftest_ctrl.sv
// xor_gate_selftest_ctrl: sweeps all a/b vectors into a 2-input XOR gate, compares y to a^b and
// reports a saturating mismatch count, the first failing vector and pass/fail via a start/done handshake.
module xor_gate_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    xor_gate_selftest_ctrl_if.slave        host,
    output logic                           dut_a_o,
    output logic                           dut_b_o,
    input  logic                           dut_y_i
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PLAST = PW'(PASSES - 1);
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    state_t           state_q;
    logic [1:0]       vec_q, vec_d;
    logic [PW-1:0]    pidx_q;
    logic [SW-1:0]    settle_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       fvec_q;
    logic             fseen_q, busy_q, done_q, pass_q, a_q, b_q, mismatch;
    always_comb begin
        mismatch = dut_y_i != (vec_q[1] ^ vec_q[0]);
        err_d    = (mismatch && err_q != '1) ? err_q + 1'b1 : err_q;
        vec_d    = vec_q + 2'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            pidx_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fseen_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else if (host.abort) begin
            // Abort wins in every state; partial results stay visible.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (host.start) begin
                    state_q <= APPLY;
                    vec_q   <= '0;
                    pidx_q  <= '0;
                    err_q   <= '0;
                    fvec_q  <= '0;
                    fseen_q <= 1'b0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                end
                APPLY: begin
                    state_q  <= SETTLE_CYCLES > 0 ? SETTLE : CHECK;
                    settle_q <= '0;
                end
                SETTLE: begin
                    state_q  <= settle_q == SLAST ? CHECK : SETTLE;
                    settle_q <= settle_q + 1'b1;
                end
                CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !fseen_q) begin
                        fvec_q  <= vec_q;
                        fseen_q <= 1'b1;
                    end
                    if (vec_q != 2'b11 || pidx_q != PLAST) begin
                        // Next vector; 11 wraps to 00 for the following sweep.
                        state_q <= APPLY;
                        vec_q   <= vec_d;
                        a_q     <= vec_d[1];
                        b_q     <= vec_d[0];
                        if (vec_q == 2'b11) pidx_q <= pidx_q + 1'b1;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == '0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.pass      = pass_q;
    assign host.err_count = err_q;
    assign host.fail_vec  = fvec_q;
    assign host.fail_seen = fseen_q;
    assign dut_a_o        = a_q;
    assign dut_b_o        = b_q;
endmodule

// File: tb/tb_xor_gate_selftest_ctrl.sv
// tb_xor_gate_selftest_ctrl: drives default and PASSES=3/ERR_W=2 sequencers against modelled good and faulty gates.
module tb_xor_gate_selftest_ctrl;
    typedef struct {
        logic [2:0] mode;
        int         err;
        logic [1:0] fvec;
        logic       fseen;
        logic       pass;
        int         lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a0, b0, y0, a1, b1, y1;
    logic [2:0] mode0 = 3'd0, mode1 = 3'd0;
    int checks = 0, failures = 0;
    vec_t tab[5];
    vec_t q[$];
    xor_gate_selftest_ctrl_if #(.ERR_W(4)) h0 ();
    xor_gate_selftest_ctrl_if #(.ERR_W(2)) h1 ();
    xor_gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .host(h0.slave), .dut_a_o(a0), .dut_b_o(b0), .dut_y_i(y0));
    xor_gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .host(h1.slave), .dut_a_o(a1), .dut_b_o(b1), .dut_y_i(y1));
    always #5 clk = ~clk;
    // Gate models: 0 xor, 1 nand, 2 stuck-0, 3 stuck-1, 4 xnor.
    function automatic logic gate(input logic [2:0] m, input logic a, input logic b);
        return m == 3'd0 ? a ^ b : m == 3'd1 ? ~(a & b) : m == 3'd2 ? 1'b0 : m == 3'd3 ? 1'b1 : ~(a ^ b);
    endfunction
    assign y0 = gate(mode0, a0, b0);
    assign y1 = gate(mode1, a1, b1);
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic run0(input vec_t v);
        vec_t e;
        int cnt;
        q.push_back(v);
        mode0 = v.mode;
        h0.start = 1'b1;
        step;
        h0.start = 1'b0;
        chk("busy_after_accept", int'(h0.busy), 1);
        cnt = 0;
        while (!h0.done && cnt < 200) begin
            step;
            cnt++;
        end
        e = q.pop_front();
        chk("done_latency", cnt, e.lat);
        chk("busy_in_done", int'(h0.busy), 0);
        chk("err_count", int'(h0.err_count), e.err);
        chk("fail_vec", int'(h0.fail_vec), int'(e.fvec));
        chk("fail_seen", int'(h0.fail_seen), int'(e.fseen));
        chk("pass", int'(h0.pass), int'(e.pass));
        chk("dut_ab_in_done", int'({a0, b0}), 0);
        step;
        chk("done_held", int'(h0.done), 1);
    endtask
    initial begin
        int cnt;
        vec_t e;
        tab[0] = '{3'd0, 0, 2'b00, 1'b0, 1'b1, 16};
        tab[1] = '{3'd1, 1, 2'b00, 1'b1, 1'b0, 16};
        tab[2] = '{3'd2, 2, 2'b01, 1'b1, 1'b0, 16};
        tab[3] = '{3'd3, 2, 2'b00, 1'b1, 1'b0, 16};
        tab[4] = '{3'd4, 4, 2'b00, 1'b1, 1'b0, 16};
        h0.start = 1'b0; h0.abort = 1'b0; h1.start = 1'b0; h1.abort = 1'b0;
        #12;
        chk("reset_outputs", int'({h0.busy, h0.done, h0.pass, h0.err_count, h0.fail_vec, h0.fail_seen, a0, b0}), 0);
        @(negedge clk) rst_n = 1'b1;
        step;
        chk("idle_outputs", int'({h0.busy, h0.done, a0, b0}), 0);
        for (int i = 0; i < 5; i++) run0(tab[i]);
        h0.start = 1'b1; h0.abort = 1'b1;
        step;
        h0.start = 1'b0; h0.abort = 1'b0;
        chk("abort_beats_start_done", int'(h0.done), 0);
        chk("abort_beats_start_busy", int'(h0.busy), 0);
        // Three passes with a stuck-1 gate: six mismatches saturate a 2-bit counter.
        q.push_back('{3'd3, 3, 2'b00, 1'b1, 1'b0, 48});
        mode1 = 3'd3;
        h1.start = 1'b1;
        step;
        h1.start = 1'b0;
        cnt = 0;
        while (!h1.done && cnt < 400) begin
            step;
            cnt++;
        end
        e = q.pop_front();
        chk("p3_done_latency", cnt, e.lat);
        chk("p3_err_sat", int'(h1.err_count), e.err);
        chk("p3_fail_vec", int'(h1.fail_vec), int'(e.fvec));
        chk("p3_fail_seen", int'(h1.fail_seen), int'(e.fseen));
        chk("p3_pass", int'(h1.pass), int'(e.pass));
        // Start pulsed during SETTLE of vector 10 must not disturb the run.
        q.push_back(tab[0]);
        mode0 = 3'd0;
        h0.start = 1'b1;
        step;
        h0.start = 1'b0;
        cnt = 0;
        repeat (9) begin step; cnt++; end
        chk("settle_vec10_ab", int'({a0, b0}), 2);
        h0.start = 1'b1;
        step;
        cnt++;
        h0.start = 1'b0;
        while (!h0.done && cnt < 200) begin
            step;
            cnt++;
        end
        e = q.pop_front();
        chk("ignored_start_latency", cnt, e.lat);
        chk("ignored_start_pass", int'(h0.pass), int'(e.pass));
        // Abort in CHECK of vector 11 with an xnor gate: the aborting mismatch is not counted.
        mode0 = 3'd4;
        h0.start = 1'b1;
        step;
        h0.start = 1'b0;
        repeat (15) step;
        chk("check_vec11_ab", int'({a0, b0}), 3);
        h0.abort = 1'b1;
        step;
        h0.abort = 1'b0;
        chk("abort_busy", int'(h0.busy), 0);
        chk("abort_done", int'(h0.done), 0);
        chk("abort_ab", int'({a0, b0}), 0);
        chk("abort_err_partial", int'(h0.err_count), 3);
        chk("abort_fail_seen", int'(h0.fail_seen), 1);
        chk("abort_fail_vec", int'(h0.fail_vec), 0);
        repeat (3) step;
        chk("abort_stays_idle", int'({h0.busy, h0.done}), 0);
        // Asynchronous reset during SETTLE of vector 01.
        h0.start = 1'b1;
        step;
        h0.start = 1'b0;
        repeat (5) step;
        chk("settle_vec01_ab", int'({a0, b0}), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ab", int'({a0, b0}), 0);
        chk("async_rst_busy", int'(h0.busy), 0);
        chk("async_rst_err", int'(h0.err_count), 0);
        chk("async_rst_fail_seen", int'(h0.fail_seen), 0);
        @(negedge clk) rst_n = 1'b1;
        step;
        run0(tab[0]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
